// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake bundle for uart_tx_fifo: character data, valid and ready.
// The producer uses the master modport, the transmitter uses the slave modport.
interface uart_tx_fifo_if #(
    parameter int MAX_DW = 9
);
    logic [MAX_DW-1:0] wr_data;
    logic              wr_vld;
    logic              wr_rdy;

    modport master (
        output wr_data,
        output wr_vld,
        input  wr_rdy
    );

    modport slave (
        input  wr_data,
        input  wr_vld,
        output wr_rdy
    );
endinterface : uart_tx_fifo_if

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO in front of it.
// Frames are start bit, 5..MAX_DW data bits LSB first, optional parity, 1 or 2
// stop bits; the line advances only on cycles where the baud tick is high.
// Optional feature macro: UART_TX_BREAK_EN adds the brk input and a BREAK state
// that holds the line low while brk stays high.
module uart_tx_fifo #(
    parameter int MAX_DW = 9,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      tick,
    uart_tx_fifo_if.slave             wr,
    input  logic [3:0]                cfg_data_len,
    input  logic                      cfg_parity_en,
    input  logic                      cfg_parity_even,
    input  logic [1:0]                cfg_stop_len,
`ifdef UART_TX_BREAK_EN
    input  logic                      brk,
`endif
    output logic                      txd,
    output logic                      busy,
    output logic                      done,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`endif

    // XOR of the low 'len' bits of a character (even-parity value).
    function automatic logic parity_of(input logic [MAX_DW-1:0] d, input logic [3:0] len);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < int'(len)) begin
                p = p ^ d[i];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    // ---------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ---------------------------------------------------------------
    logic [MAX_DW-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              rdy_q, rdy_d;
    logic              push_s;
    logic              pop_s;
    logic [MAX_DW-1:0] head_s;

    // ---------------------------------------------------------------
    // Transmitter state
    // ---------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [MAX_DW-1:0] shift_q, shift_d;
    logic [3:0]        len_q, len_d;
    logic              par_en_q, par_en_d;
    logic              par_q, par_d;
    logic              stop2_q, stop2_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              launch_s;
    logic [3:0]        len_clamp_s;

    assign head_s = mem_q[rd_ptr_q];

    // Full/empty are the registered start-of-cycle view, so a push while full is
    // dropped even if a pop frees a slot in the same cycle.
    always_comb begin
        push_s   = wr.wr_vld & ~full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = level_q + LW'(push_s) - LW'(pop_s);
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == LW'(0));
        rdy_d   = ~full_d;
    end

    // FIFO pointer and status registers; reset flushes the queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rdy_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            rdy_q    <= rdy_d;
        end
    end

    // FIFO data array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr.wr_data;
        end
    end

    // Data length clamped into the range the shifter can send.
    always_comb begin
        if (cfg_data_len < 4'd5) begin
            len_clamp_s = 4'd5;
        end else if (cfg_data_len > 4'(MAX_DW)) begin
            len_clamp_s = 4'(MAX_DW);
        end else begin
            len_clamp_s = cfg_data_len;
        end
    end

    // Frame sequencer: next state, next line bit and FIFO pop, advancing only on tick.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        len_d    = len_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        txd_d    = txd_q;
        done_d   = 1'b0;
        pop_s    = 1'b0;
        launch_s = 1'b0;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (brk) begin
                        state_d = S_BREAK;
                        txd_d   = 1'b0;
                    end else if (!empty_q) begin
                        launch_s = 1'b1;
                    end else begin
                        txd_d = 1'b1;
                    end
`else
                    if (!empty_q) begin
                        launch_s = 1'b1;
                    end else begin
                        txd_d = 1'b1;
                    end
`endif
                end
                S_START: begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[MAX_DW-1:1]};
                    cnt_d   = 4'd0;
                end
                S_DATA: begin
                    if (cnt_q == (len_q - 4'd1)) begin
                        cnt_d = 4'd0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[MAX_DW-1:1]};
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    cnt_d   = 4'd0;
                end
                S_STOP: begin
                    if (cnt_q == {3'b000, stop2_q}) begin
                        // Last stop bit ends here; chain straight into the next frame.
                        done_d = 1'b1;
                        cnt_d  = 4'd0;
`ifdef UART_TX_BREAK_EN
                        if (brk) begin
                            state_d = S_BREAK;
                            txd_d   = 1'b0;
                        end else if (!empty_q) begin
                            launch_s = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                        end
`else
                        if (!empty_q) begin
                            launch_s = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        txd_d = 1'b1;
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    if (!brk) begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d = 1'b0;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                    cnt_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Frame start: pop the head and freeze the configuration for this frame.
        if (launch_s) begin
            pop_s    = 1'b1;
            state_d  = S_START;
            txd_d    = 1'b0;
            cnt_d    = 4'd0;
            shift_d  = head_s;
            len_d    = len_clamp_s;
            par_en_d = cfg_parity_en;
            par_d    = parity_of(head_s, len_clamp_s) ^ ~cfg_parity_even;
            stop2_d  = cfg_stop_len[1];
        end else begin
            pop_s = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // Transmitter registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            shift_q  <= {MAX_DW{1'b0}};
            len_q    <= 4'd5;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            len_q    <= len_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign wr.wr_rdy  = rdy_q;
    assign txd        = txd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign fifo_level = level_q;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a bit-level scoreboard receives the expected
// line bits of each queued frame, and every baud tick pops and compares one bit.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rstn;
    logic       tick;
    logic [3:0] cfg_data_len;
    logic       cfg_parity_en;
    logic       cfg_parity_even;
    logic [1:0] cfg_stop_len;
`ifdef UART_TX_BREAK_EN
    logic       brk;
`endif
    logic       txd;
    logic       busy;
    logic       done;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_level;

    uart_tx_fifo_if #(.MAX_DW(9)) wif ();

    uart_tx_fifo #(.MAX_DW(9), .DEPTH(8)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .tick            (tick),
        .wr              (wif.slave),
        .cfg_data_len    (cfg_data_len),
        .cfg_parity_en   (cfg_parity_en),
        .cfg_parity_even (cfg_parity_even),
        .cfg_stop_len    (cfg_stop_len),
`ifdef UART_TX_BREAK_EN
        .brk             (brk),
`endif
        .txd             (txd),
        .busy            (busy),
        .done            (done),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_level      (fifo_level)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    logic exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with done high; a stretched pulse shows up as extra counts.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference frame builder: start, clamped data LSB first, parity, stop bits.
    task automatic expect_frame(input logic [8:0] d, input int len_cfg, input logic pen,
                                input logic peven, input int stop_cfg);
        int   n;
        logic p;
        n = (len_cfg < 5) ? 5 : ((len_cfg > 9) ? 9 : len_cfg);
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pen) exp_q.push_back(peven ? p : ~p);
        for (int i = 0; i < ((stop_cfg >= 2) ? 2 : 1); i++) exp_q.push_back(1'b1);
    endtask

    // Called just after a tick edge: a busy line must carry the next expected bit.
    task automatic mon();
        logic b;
        if (busy === 1'b1) begin
            chk("sb_has_bit", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("line_bit", txd, b);
            end
        end else begin
            chk("idle_txd", txd, 1'b1);
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        mon();
        @(negedge clk);
    endtask

    task automatic push(input logic [8:0] d);
        @(negedge clk);
        wif.wr_data = d;
        wif.wr_vld  = 1'b1;
        @(negedge clk);
        wif.wr_vld  = 1'b0;
    endtask

    // Push and tick in the same cycle.
    task automatic push_tick(input logic [8:0] d);
        @(negedge clk);
        wif.wr_data = d;
        wif.wr_vld  = 1'b1;
        tick        = 1'b1;
        @(negedge clk);
        wif.wr_vld  = 1'b0;
        tick        = 1'b0;
        mon();
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [3:0] len, input logic pen, input logic peven,
                           input logic [1:0] stp);
        cfg_data_len    = len;
        cfg_parity_en   = pen;
        cfg_parity_even = peven;
        cfg_stop_len    = stp;
    endtask

    initial begin
        rstn        = 1'b0;
        tick        = 1'b0;
        wif.wr_data = 9'h000;
        wif.wr_vld  = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk         = 1'b0;
`endif
        set_cfg(4'd8, 1'b0, 1'b1, 2'd1);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_rdy", wif.wr_rdy, 1'b1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55, 8N1; push lands together with a tick into an empty FIFO -> no pop yet
        expect_frame(9'h055, 8, 1'b0, 1'b1, 1);
        push_tick(9'h055);
        chk("nopop_level", fifo_level, 4'd1);
        chk("nopop_busy", busy, 1'b0);
        repeat (12) do_tick();
        chk("f55_done", done_cnt, 32'd1);
        chk("f55_busy", busy, 1'b0);
        chk("f55_drained", exp_q.size(), 32'd0);

        // 0x0F3, 9 bits, even parity, 2 stop bits
        set_cfg(4'd9, 1'b1, 1'b1, 2'd2);
        expect_frame(9'h0F3, 9, 1'b1, 1'b1, 2);
        push(9'h0F3);
        repeat (15) do_tick();
        chk("f0f3_done", done_cnt, 32'd2);
        chk("f0f3_drained", exp_q.size(), 32'd0);

        // Fill past DEPTH with no ticks, then drain back-to-back
        set_cfg(4'd8, 1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 8; i++) begin
            logic [8:0] d;
            d = 9'((i * 29) + 7);
            expect_frame(d, 8, 1'b0, 1'b1, 1);
            push(d);
        end
        chk("full_rdy_low", wif.wr_rdy, 1'b0);
        push(9'h1AB);
        chk("full_flag", fifo_full, 1'b1);
        chk("full_level", fifo_level, 4'd8);
        push_tick(9'h155);
        chk("full_push_pop_level", fifo_level, 4'd7);
        repeat (81) do_tick();
        chk("b2b_done", done_cnt, 32'd10);
        chk("b2b_drained", exp_q.size(), 32'd0);
        chk("b2b_empty", fifo_empty, 1'b1);

        // Length change mid-frame; simultaneous push and pop keeps level
        expect_frame(9'h0C3, 8, 1'b0, 1'b1, 1);
        expect_frame(9'h01A, 5, 1'b0, 1'b1, 1);
        push(9'h0C3);
        push_tick(9'h01A);
        chk("pushpop_level", fifo_level, 4'd1);
        repeat (4) do_tick();
        cfg_data_len = 4'd5;
        repeat (14) do_tick();
        chk("len_chg_done", done_cnt, 32'd12);
        chk("len_chg_drained", exp_q.size(), 32'd0);

        // Length 3 clamps to 5; odd parity; stop length 0 acts as 1
        set_cfg(4'd3, 1'b1, 1'b0, 2'd0);
        expect_frame(9'h1D6, 3, 1'b1, 1'b0, 1);
        push(9'h1D6);
        repeat (10) do_tick();
        chk("len3_done", done_cnt, 32'd13);
        chk("len3_drained", exp_q.size(), 32'd0);

        // Reset in the middle of the data bits
        set_cfg(4'd8, 1'b0, 1'b1, 2'd1);
        expect_frame(9'h03C, 8, 1'b0, 1'b1, 1);
        expect_frame(9'h02E, 8, 1'b0, 1'b1, 1);
        push(9'h03C);
        push(9'h02E);
        repeat (4) do_tick();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_txd", txd, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_empty", fifo_empty, 1'b1);
        chk("arst_level", fifo_level, 4'd0);
        chk("arst_rdy", wif.wr_rdy, 1'b1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (15) do_tick();
        chk("arst_no_done", done_cnt, 32'd13);
        chk("arst_still_empty", fifo_empty, 1'b1);

`ifdef UART_TX_BREAK_EN
        // Break requested mid-frame: frame completes, 20 low bits, then data resumes
        expect_frame(9'h0A6, 8, 1'b0, 1'b1, 1);
        for (int i = 0; i < 20; i++) exp_q.push_back(1'b0);
        push(9'h0A6);
        push(9'h059);
        repeat (3) do_tick();
        brk = 1'b1;
        repeat (8) do_tick();
        repeat (19) do_tick();
        chk("brk_low", txd, 1'b0);
        brk = 1'b0;
        do_tick();
        chk("brk_exit_txd", txd, 1'b1);
        chk("brk_exit_busy", busy, 1'b0);
        chk("brk_no_done", done_cnt, 32'd14);
        expect_frame(9'h059, 8, 1'b0, 1'b1, 1);
        repeat (12) do_tick();
        chk("brk_resume_done", done_cnt, 32'd15);
        chk("brk_drained", exp_q.size(), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_tx_fifo
